fifo_uart_tx: RTL

//  Downstream drain stage for the RAM-based FIFO. Pops one WIDTH-bit word at a time and

---
 rtl/fifo_uart_pkg.sv | 17 +
 rtl/uart_baud_cnt.sv | 31 +++
 rtl/fifo_uart_tx.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-to-UART drain stage: FSM state encoding and
// the default bit period.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } uart_state_t;

    localparam int DEF_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: tick marks the last clk of each CLKS_PER_BIT period,
// clr restarts a full period on the following cycle.
module uart_baud_cnt
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic res_n,
    input  logic clr,
    output logic tick
);

    localparam int                CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_cnt <= RELOAD;
        end else if (clr || (r_cnt == '0)) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign tick = (r_cnt == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a RAM-based FIFO one word at a time and serialises each word as a UART
// frame: start bit, data LSB first, optional parity, STOP_BITS stop bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_shift_out,
    output logic             tx,
    output logic             busy
);

    localparam int               IDX_W     = $clog2(WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);

    uart_state_t      r_state;
    logic [WIDTH-1:0] r_shreg;
    logic             r_par;
    logic [IDX_W-1:0] r_idx;
    logic             r_tx;
    logic             r_busy;
    logic             r_shift_out;
    logic             w_tick;
    logic             w_clr;

    // The bit timer is held in reload while no bit is on the line, so every
    // timed state begins with a full bit period.
    assign w_clr = (r_state == IDLE) || (r_state == FETCH) || (r_state == LOAD);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .res_n(res_n),
        .clr  (w_clr),
        .tick (w_tick)
    );

    // tx is registered from the current state, so the line lags the FSM by one
    // clk; the extra IDLE cycle with busy still set covers that lag.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_shift_out <= 1'b0;
        end else begin
            r_shift_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (enable && !fifo_empty) begin
                        r_shift_out <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= FETCH;
                    end
                end
                FETCH: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_state <= START;
                end
                START: begin
                    r_tx <= 1'b0;
                    if (w_tick) begin
                        r_idx   <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    r_tx <= r_shreg[0];
                    if (w_tick) begin
                        if (r_idx == LAST_DATA) begin
                            r_idx   <= '0;
                            r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    r_tx <= r_par;
                    if (w_tick) begin
                        r_idx   <= '0;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    r_tx <= 1'b1;
                    if (w_tick) begin
                        if (r_idx == LAST_STOP) begin
                            r_idx   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == LOAD) begin
            r_shreg <= fifo_rdata;
            r_par   <= (^fifo_rdata) ^ PAR_ODD;
        end else if ((r_state == DATA) && w_tick) begin
            r_shreg <= r_shreg >> 1;
        end
    end

    assign fifo_shift_out = r_shift_out;
    assign tx             = r_tx;
    assign busy           = r_busy;

endmodule
